sopc_pio_out_ext: RTL and testbench
===================================

SOPC_PIO_OUT_EXT -- requirements
Module: sopc_pio_out_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning output port width (1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, meaning DATA register value after reset.
REQ-003 SHALL have parameter CNT_W, default 16, meaning pulse counter width (1..32).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port address, input, 3, meaning Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1, meaning slave select.
REQ-008 SHALL have port write_n, input, 1, meaning active-low write strobe.
REQ-009 SHALL have port read_n, input, 1, meaning active-low read strobe.
REQ-010 SHALL have port writedata, input, 32, meaning write data.
REQ-011 SHALL have port readdata, output, 32, meaning read data, registered, read latency 1.
REQ-012 SHALL have port out_port, output, DATA_WIDTH, meaning DATA register driven directly.

Function
REQ-013 SHALL decode the register map as follows: 0 DATA (RW), 1 PULSE_MASK (RW), 2 PULSE_LEN (RW, CNT_W bits), 3 STATUS (RO, bit0 = busy), 4 SET (WO), 5 CLEAR (WO), 6 TOGGLE (WO), 7 reserved (reads 0, writes ignored).
REQ-014 SHALL qualify a write as chipselect && !write_n, and a read as chipselect && !read_n.
REQ-015 SHALL make a write take effect on out_port at the next rising edge: DATA <= wd, SET <= DATA|wd, CLEAR <= DATA&~wd, TOGGLE <= DATA^wd.
REQ-016 SHALL ignore writedata bits at or above DATA_WIDTH (or CNT_W for PULSE_LEN), and SHALL zero-extend all unused bits on readdata.
REQ-017 SHALL return the selected register on readdata one cycle after a read; WO registers (4-6) SHALL read 0; readdata SHALL hold its value when no read is in progress.
REQ-018 SHALL start a pulse when a write to DATA, SET, or TOGGLE drives any PULSE_MASK bit from 0 to 1: the counter loads PULSE_LEN and busy is set.
REQ-019 SHALL decrement the counter by 1 per cycle while busy; on the cycle the counter reaches 0 while busy, it SHALL clear every DATA bit that is set in PULSE_MASK and clear busy. A pulsed bit is therefore high for PULSE_LEN+1 cycles (PULSE_LEN=0 gives a 1-cycle pulse).
REQ-020 SHALL treat a retrigger while busy (a new 0->1 edge on a masked bit) as reloading the counter with PULSE_LEN; previously pulsed bits stay high until the new expiry.
REQ-021 SHALL apply expiry and a simultaneous bus write in this order: the expiry clear applies first, then the write result is computed from the post-expiry DATA, and a pulse start in that same cycle reloads the counter and keeps busy set.
REQ-022 SHALL not affect a running counter when PULSE_MASK or PULSE_LEN is written; the new values apply from the next pulse start or expiry.
REQ-023 SHALL leave bits outside PULSE_MASK unaffected by the pulse logic.

Reset
REQ-024 SHALL, while reset is high at a clock edge, set DATA=RESET_VALUE, PULSE_MASK=0, PULSE_LEN=0, counter=0, busy=0, readdata=0; reset SHALL take priority over any simultaneous bus access.
REQ-025 SHALL abort a pulse in progress when reset is asserted mid-pulse, with no expiry clear occurring after reset releases.

Structure
REQ-026 SHALL keep the register offset constants (ADDR_DATA..ADDR_TOGGLE) and the STATUS bit index in a shared package, sopc_pio_pkg.
REQ-027 SHALL implement the counter, busy flag, load/retrigger, and expiry strobe in one sub-module, sopc_pio_pulse_timer.

Verification
REQ-028 SHALL verify: reset, then write DATA=0xA5A5_A5A5 -> out_port=0xA5A5A5A5 next cycle; a read of addr 0 returns 0xA5A5A5A5 one cycle after read_n.
REQ-029 SHALL verify: DATA=0x0F, SET 0xF0, CLEAR 0x03, TOGGLE 0x101 -> out_port sequence 0xFF, 0xFC, 0x1FD.
REQ-030 SHALL verify: PULSE_MASK=0x1, PULSE_LEN=3, SET 0x1 -> bit0 high exactly 4 cycles; STATUS bit0=1 during the pulse and 0 after.
REQ-031 SHALL verify: PULSE_LEN=5, SET 0x1, then CLEAR 0x1 and SET 0x1 two cycles later -> counter reloads and bit0 falls 6 cycles after the second SET.
REQ-032 SHALL verify: a SET 0x2 (unmasked) write on the expiry cycle -> bit0 clears and bit1 sets on the same edge, with busy=0.
REQ-033 SHALL verify: reset asserted mid-pulse with RESET_VALUE=0x8 -> out_port=0x8, busy=0, and no later spurious clear.

Source files
------------

// File: rtl/sopc_pio_pkg.sv
// Shared register map and helpers for the Avalon-MM output PIO with pulse support.
package sopc_pio_pkg;

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_MASK   = 3'd1;
   localparam logic [2:0] ADDR_LEN    = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_SET    = 3'd4;
   localparam logic [2:0] ADDR_CLEAR  = 3'd5;
   localparam logic [2:0] ADDR_TOGGLE = 3'd6;

   localparam int STATUS_BUSY_BIT = 0;

   // Only these writes can raise a DATA bit, so only they can start a pulse.
   function automatic logic is_pulse_source(input logic [2:0] addr);
      return (addr == ADDR_DATA) || (addr == ADDR_SET) || (addr == ADDR_TOGGLE);
   endfunction

endpackage

// File: rtl/sopc_pio_pulse_timer.sv
// Pulse down-counter: load/retrigger on start, expiry strobe when it reaches zero while busy.
module sopc_pio_pulse_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_reg;
   logic             busy_reg;

   assign busy   = busy_reg;
   assign expire = busy_reg && (cnt_reg == '0);

   // A start on the expiry cycle wins: the counter reloads and busy stays set.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg  <= '0;
         busy_reg <= 1'b0;
      end else if (start) begin
         cnt_reg  <= len;
         busy_reg <= 1'b1;
      end else if (expire) begin
         busy_reg <= 1'b0;
      end else if (busy_reg) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

endmodule

// File: rtl/sopc_pio_out_ext.sv
// Avalon-MM output PIO with set/clear/toggle aliases and self-clearing pulsed bits.
module sopc_pio_out_ext
   import sopc_pio_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic                  read_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [DATA_WIDTH-1:0] data_post;
   logic [DATA_WIDTH-1:0] data_next;
   logic [DATA_WIDTH-1:0] mask_reg;
   logic [DATA_WIDTH-1:0] rise;
   logic [CNT_W-1:0]      len_reg;
   logic [31:0]           readdata_reg;
   logic [31:0]           readdata_next;
   logic                  busy;
   logic                  expire;
   logic                  start;

   assign wr_en    = chipselect && !write_n;
   assign rd_en    = chipselect && !read_n;
   assign wd       = writedata[DATA_WIDTH-1:0];
   assign out_port = data_reg;
   assign readdata = readdata_reg;

   // Expiry clears first; the bus write then operates on the post-expiry value.
   assign data_post = expire ? (data_reg & ~mask_reg) : data_reg;

   always_comb begin
      data_next = data_post;
      if (wr_en) begin
         case (address)
            ADDR_DATA:   data_next = wd;
            ADDR_SET:    data_next = data_post | wd;
            ADDR_CLEAR:  data_next = data_post & ~wd;
            ADDR_TOGGLE: data_next = data_post ^ wd;
            default:     data_next = data_post;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rise
         assign rise[gi] = mask_reg[gi] && !data_post[gi] && data_next[gi];
      end
   endgenerate

   assign start = wr_en && is_pulse_source(address) && (|rise);

   sopc_pio_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .len    (len_reg),
      .busy   (busy),
      .expire (expire)
   );

   always_comb begin
      readdata_next = '0;
      case (address)
         ADDR_DATA:   readdata_next = 32'(data_reg);
         ADDR_MASK:   readdata_next = 32'(mask_reg);
         ADDR_LEN:    readdata_next = 32'(len_reg);
         ADDR_STATUS: readdata_next[STATUS_BUSY_BIT] = busy;
         default:     readdata_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg     <= RESET_VALUE;
         mask_reg     <= '0;
         len_reg      <= '0;
         readdata_reg <= '0;
      end else begin
         data_reg <= data_next;
         if (wr_en && address == ADDR_MASK) begin
            mask_reg <= wd;
         end
         if (wr_en && address == ADDR_LEN) begin
            len_reg <= writedata[CNT_W-1:0];
         end
         if (rd_en) begin
            readdata_reg <= readdata_next;
         end
      end
   end

endmodule

// File: tb/tb_sopc_pio_out_ext.sv
// Directed bench for sopc_pio_out_ext: register map, aliases, pulse timing, retrigger, reset abort.
module tb_sopc_pio_out_ext;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic        read_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [31:0] out_port;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   sopc_pio_out_ext #(
      .DATA_WIDTH  (32),
      .RESET_VALUE (32'h8),
      .CNT_W       (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .read_n     (read_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_rd(input logic [2:0] a);
      chipselect = 1'b1;
      read_n     = 1'b0;
      address    = a;
      tick();
      chipselect = 1'b0;
      read_n     = 1'b1;
   endtask

   initial begin
      // Reset with a competing write: reset must win.
      reset      = 1'b1;
      chipselect = 1'b1;
      write_n    = 1'b0;
      read_n     = 1'b1;
      address    = 3'd0;
      writedata  = 32'hFFFF_FFFF;
      tick();
      tick();
      check("reset_out", out_port, 32'h8);
      check("reset_rd", readdata, 32'h0);
      chipselect = 1'b0;
      write_n    = 1'b1;
      reset      = 1'b0;
      bus_rd(3'd3);
      check("reset_status", readdata, 32'h0);
      bus_rd(3'd2);
      check("reset_len", readdata, 32'h0);

      // Basic DATA write and readback.
      bus_wr(3'd0, 32'hA5A5_A5A5);
      check("data_wr", out_port, 32'hA5A5_A5A5);
      bus_rd(3'd0);
      check("data_rd", readdata, 32'hA5A5_A5A5);
      tick();
      check("rd_hold", readdata, 32'hA5A5_A5A5);

      // SET / CLEAR / TOGGLE aliases.
      bus_wr(3'd0, 32'h0F);
      check("data_0f", out_port, 32'h0F);
      bus_wr(3'd4, 32'hF0);
      check("set_f0", out_port, 32'hFF);
      bus_wr(3'd5, 32'h03);
      check("clr_03", out_port, 32'hFC);
      bus_wr(3'd6, 32'h101);
      check("tgl_101", out_port, 32'h1FD);
      bus_wr(3'd7, 32'hFFFF_FFFF);
      check("rsvd_wr", out_port, 32'h1FD);
      bus_rd(3'd7);
      check("rsvd_rd", readdata, 32'h0);
      bus_rd(3'd4);
      check("wo_rd", readdata, 32'h0);

      // Pulse with PULSE_LEN=3: bit0 high for exactly 4 cycles.
      bus_wr(3'd0, 32'h0);
      bus_wr(3'd1, 32'h1);
      bus_wr(3'd2, 32'hFFFF_0003);
      bus_rd(3'd2);
      check("len_rd_trunc", readdata, 32'h3);
      bus_rd(3'd1);
      check("mask_rd", readdata, 32'h1);
      bus_wr(3'd4, 32'h1);
      check("p3_c0", out_port, 32'h1);
      bus_rd(3'd3);
      check("p3_busy", readdata, 32'h1);
      check("p3_c1", out_port, 32'h1);
      tick();
      check("p3_c2", out_port, 32'h1);
      tick();
      check("p3_c3", out_port, 32'h1);
      tick();
      check("p3_end", out_port, 32'h0);
      bus_rd(3'd3);
      check("p3_idle", readdata, 32'h0);

      // Retrigger: PULSE_LEN=5, SET, CLEAR two cycles later, SET again.
      bus_wr(3'd2, 32'h5);
      bus_wr(3'd4, 32'h1);
      tick();
      bus_wr(3'd5, 32'h1);
      check("rt_clr", out_port, 32'h0);
      bus_wr(3'd4, 32'h1);
      check("rt_c0", out_port, 32'h1);
      for (int i = 1; i <= 5; i++) begin
         tick();
         check($sformatf("rt_c%0d", i), out_port, 32'h1);
      end
      tick();
      check("rt_end", out_port, 32'h0);

      // Unmasked SET on the expiry cycle (PULSE_LEN=2).
      bus_wr(3'd2, 32'h2);
      bus_wr(3'd4, 32'h1);
      tick();
      tick();
      check("ex_pre", out_port, 32'h1);
      bus_wr(3'd4, 32'h2);
      check("ex_same_edge", out_port, 32'h2);
      bus_rd(3'd3);
      check("ex_busy", readdata, 32'h0);

      // Reset mid-pulse, then make bit3 masked: a stale expiry would clear it.
      bus_wr(3'd2, 32'h3);
      bus_wr(3'd4, 32'h1);
      check("rs_start", out_port, 32'h3);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rs_out", out_port, 32'h8);
      bus_wr(3'd1, 32'h8);
      bus_rd(3'd3);
      check("rs_busy", readdata, 32'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("rs_hold%0d", i), out_port, 32'h8);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
